// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bus of the sprite ROM arbiter.
//   en        : allow new grants (low freezes arbitration, reads in flight still finish)
//   req       : per-requester level request
//   req_addr  : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt       : one-hot grant pulse
//   rsp_valid : one-hot response strobe, two cycles after gnt
//   rsp_data  : palette index returned by the ROM
//   busy      : a read is granted or still in the pipeline
interface sprite_rom_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 3
);
    logic                        en;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [DATA_W-1:0]           rsp_data;
    logic                        busy;

    modport master (
        output en, req, req_addr,
        input  gnt, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  en, req, req_addr,
        output gnt, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM (1-cycle read
// latency) between NUM_REQ pixel-fetch requesters, one read per vga_clk.
// Ports:
//   vga_clk, reset_n : pixel clock, asynchronous active-low reset
//   bus              : requester side (en, req, req_addr, gnt, rsp_valid, rsp_data, busy)
//   rom_address      : registered ROM address
//   rom_q            : ROM data, valid one cycle after rom_address is sampled
module sprite_rom_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 3
) (
    input  logic                  vga_clk,
    input  logic                  reset_n,
    sprite_rom_arbiter_if.slave   bus,
    output logic [ADDR_W-1:0]     rom_address,
    input  logic [DATA_W-1:0]     rom_q
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   winner;
    logic               grant_c;
    logic [ADDR_W-1:0]  addr_slice [NUM_REQ];

    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               busy_q;
    logic               valid_a;
    logic               valid_b;
    logic [PTR_W-1:0]   id_a;
    logic [PTR_W-1:0]   id_b;

    // Requester index at offset off from the priority pointer, modulo NUM_REQ.
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base,
                                                input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        return PTR_W'(sum % NUM_REQ);
    endfunction

    // Unpack the flat address bus into one slot per requester.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign addr_slice[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    end

    // Winner search: first active request at or after the pointer.
    always_comb begin
        grant_c = 1'b0;
        winner  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!grant_c && bus.req[rr_idx(ptr, k)]) begin
                grant_c = 1'b1;
                winner  = rr_idx(ptr, k);
            end
        end
        grant_c = grant_c & bus.en;
    end

    // Grant, ROM address and two-stage read pipeline.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr         <= '0;
            gnt_q       <= '0;
            rom_address <= '0;
            valid_a     <= 1'b0;
            valid_b     <= 1'b0;
            id_a        <= '0;
            id_b        <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            valid_a <= grant_c;
            valid_b <= valid_a;
            id_b    <= id_a;
            // Registered form of valid_a | valid_b | |gnt as seen after this edge.
            busy_q  <= grant_c | valid_a;
            if (grant_c) begin
                gnt_q       <= NUM_REQ'(1) << winner;
                rom_address <= addr_slice[winner];
                id_a        <= winner;
                ptr         <= (winner == LAST_IDX) ? '0 : PTR_W'(winner + 1'b1);
            end else begin
                gnt_q <= '0;
            end
            rsp_valid_q <= valid_b ? (NUM_REQ'(1) << id_b) : '0;
            // Data holds between responses so downstream sees a stable index.
            if (valid_b) begin
                rsp_data_q <= rom_q;
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed testbench for sprite_rom_arbiter with a behavioural 1-cycle ROM.
module tb_sprite_rom_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned DATA_W  = 3;

    logic               vga_clk;
    logic               reset_n;
    logic [ADDR_W-1:0]  rom_address;
    logic [DATA_W-1:0]  rom_q;

    int n_cmp = 0;
    int n_err = 0;

    sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .rom_address (rom_address),
        .rom_q       (rom_q)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        return a[2:0] ^ a[8:6];
    endfunction

    function automatic logic [ADDR_W-1:0] rr_addr(input int i);
        return ADDR_W'(40 + 13 * i);
    endfunction

    always_ff @(posedge vga_clk) rom_q <= rom_fn(rom_address);

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req = '0;
        bus.en  = 1'b1;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.en       = 1'b1;
        bus.req      = '0;
        bus.req_addr = '0;
        step();
        step();
        n_cmp++;
        if (bus.gnt !== 4'b0 || rom_address !== 9'd0 || bus.rsp_valid !== 4'b0 ||
            bus.rsp_data !== 3'd0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init: gnt=%b addr=%0d rsp_valid=%b rsp_data=%0d busy=%b, want all 0",
                     bus.gnt, rom_address, bus.rsp_valid, bus.rsp_data, bus.busy);
        end
        reset_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_addr(i, rr_addr(i));
        bus.req = 4'b1111;
        step();
        step();
        step();
        // Reset mid-cycle with reads in flight.
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.gnt !== 4'b0 || rom_address !== 9'd0 || bus.rsp_valid !== 4'b0 ||
            bus.rsp_data !== 3'd0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: gnt=%b addr=%0d rsp_valid=%b rsp_data=%0d busy=%b, want all 0",
                     bus.gnt, rom_address, bus.rsp_valid, bus.rsp_data, bus.busy);
        end
        bus.req = '0;
        step();
        reset_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            n_cmp++;
            if (bus.rsp_valid !== 4'b0 || bus.busy !== 1'b0 || bus.gnt !== 4'b0) begin
                n_err++;
                $display("FAIL reset_release c%0d: rsp_valid=%b busy=%b gnt=%b, want 0/0/0",
                         c, bus.rsp_valid, bus.busy, bus.gnt);
            end
        end
    endtask

    task automatic test_single_read();
        do_reset();
        set_addr(1, 9'd37);
        bus.req = 4'b0010;
        step();
        n_cmp++;
        if (bus.gnt !== 4'b0010 || rom_address !== 9'd37 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_gnt: gnt=%b addr=%0d busy=%b, want 0010/37/1",
                     bus.gnt, rom_address, bus.busy);
        end
        bus.req = '0;
        step();
        n_cmp++;
        if (bus.gnt !== 4'b0 || bus.rsp_valid !== 4'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_c2: gnt=%b rsp_valid=%b busy=%b, want 0000/0000/1",
                     bus.gnt, bus.rsp_valid, bus.busy);
        end
        step();
        n_cmp++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 3'd5) begin
            n_err++;
            $display("FAIL single_rsp: rsp_valid=%b rsp_data=%0d, want 0010/5",
                     bus.rsp_valid, bus.rsp_data);
        end
        step();
        n_cmp++;
        if (bus.rsp_valid !== 4'b0 || bus.rsp_data !== 3'd5 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: rsp_valid=%b rsp_data=%0d busy=%b, want 0000/5/0",
                     bus.rsp_valid, bus.rsp_data, bus.busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        int         r;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_addr(i, rr_addr(i));
        bus.req = 4'b1111;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_g = (c <= 8) ? (4'b0001 << ((c - 1) % 4)) : 4'b0000;
            n_cmp++;
            if (bus.gnt !== exp_g) begin
                n_err++;
                $display("FAIL rr_gnt c%0d: got %b, want %b", c, bus.gnt, exp_g);
            end
            if (c >= 3) begin
                r = (c - 3) % 4;
                n_cmp++;
                if (bus.rsp_valid !== (4'b0001 << r) || bus.rsp_data !== rom_fn(rr_addr(r))) begin
                    n_err++;
                    $display("FAIL rr_rsp c%0d: rsp_valid=%b data=%0d, want %b/%0d",
                             c, bus.rsp_valid, bus.rsp_data, 4'b0001 << r, rom_fn(rr_addr(r)));
                end
            end
            if (c == 8) bus.req = '0;
        end
    endtask

    task automatic test_skip_wrap();
        logic [3:0] exp_g;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_addr(i, rr_addr(i));
        bus.req = 4'b1001;
        for (int c = 1; c <= 4; c++) begin
            step();
            exp_g = (c % 2 == 1) ? 4'b0001 : 4'b1000;
            n_cmp++;
            if (bus.gnt !== exp_g) begin
                n_err++;
                $display("FAIL skip_gnt c%0d: got %b, want %b", c, bus.gnt, exp_g);
            end
        end
        bus.req = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_cmp++;
            if (bus.gnt !== 4'b0100 || rom_address !== rr_addr(2)) begin
                n_err++;
                $display("FAIL solo_gnt c%0d: gnt=%b addr=%0d, want 0100/%0d",
                         c, bus.gnt, rom_address, rr_addr(2));
            end
        end
        bus.req = '0;
        step();
        step();
    endtask

    task automatic test_back_to_back();
        int n_rsp;
        do_reset();
        n_rsp = 0;
        set_addr(2, 9'd0);
        bus.req = 4'b0100;
        for (int k = 0; k < 22; k++) begin
            step();
            if (k < 20) begin
                n_cmp++;
                if (bus.gnt !== 4'b0100 || rom_address !== ADDR_W'(k)) begin
                    n_err++;
                    $display("FAIL stream_gnt k%0d: gnt=%b addr=%0d, want 0100/%0d",
                             k, bus.gnt, rom_address, k);
                end
            end
            if (k >= 2) begin
                n_cmp++;
                if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== rom_fn(ADDR_W'(k - 2))) begin
                    n_err++;
                    $display("FAIL stream_rsp k%0d: rsp_valid=%b data=%0d, want 0100/%0d",
                             k, bus.rsp_valid, bus.rsp_data, rom_fn(ADDR_W'(k - 2)));
                end
            end
            if (bus.rsp_valid == 4'b0100) n_rsp++;
            if (k < 19) set_addr(2, ADDR_W'(k + 1));
            else bus.req = '0;
        end
        step();
        n_cmp++;
        if (n_rsp != 20 || bus.rsp_valid !== 4'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL stream_count: responses=%0d rsp_valid=%b busy=%b, want 20/0000/0",
                     n_rsp, bus.rsp_valid, bus.busy);
        end
    endtask

    task automatic test_en_freeze();
        int n_rsp;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_addr(i, rr_addr(i));
        bus.req = 4'b1111;
        step();
        step();
        n_cmp++;
        if (bus.gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL freeze_pre: gnt=%b, want 0010", bus.gnt);
        end
        bus.en = 1'b0;
        n_rsp  = 0;
        for (int c = 1; c <= 5; c++) begin
            step();
            n_cmp++;
            if (bus.gnt !== 4'b0) begin
                n_err++;
                $display("FAIL freeze_gnt c%0d: gnt=%b, want 0000", c, bus.gnt);
            end
            if (bus.rsp_valid != 4'b0) n_rsp++;
            if (c == 2) begin
                n_cmp++;
                if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== rom_fn(rr_addr(1)) ||
                    bus.busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL freeze_last: rsp_valid=%b data=%0d busy=%b, want 0010/%0d/0",
                             bus.rsp_valid, bus.rsp_data, bus.busy, rom_fn(rr_addr(1)));
                end
            end
        end
        n_cmp++;
        if (n_rsp != 2) begin
            n_err++;
            $display("FAIL freeze_count: responses=%0d, want 2", n_rsp);
        end
        bus.en = 1'b1;
        step();
        n_cmp++;
        if (bus.gnt !== 4'b0100) begin
            n_err++;
            $display("FAIL resume_gnt0: gnt=%b, want 0100", bus.gnt);
        end
        step();
        n_cmp++;
        if (bus.gnt !== 4'b1000) begin
            n_err++;
            $display("FAIL resume_gnt1: gnt=%b, want 1000", bus.gnt);
        end
        bus.req = '0;
        step();
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_skip_wrap();
        test_back_to_back();
        test_en_freeze();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
